// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencer feeding a 2-entry {pc, instr} fetch buffer to decode, with redirect flush and end-of-image halt
module fetch_controller #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter logic [63:0] LAST_ADDR = 64'd144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        halted,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t      state, state_nx;
    logic [63:0] pc, pc_nx;
    logic [1:0]  count;
    logic [63:0] pc_q [2];
    logic [31:0] instr_q [2];
    logic        push, pop, flush, err_set, slot;
    assign Inst_Address = pc;
    assign if_valid     = count != 2'd0;
    assign if_instr     = instr_q[0];
    assign if_pc        = pc_q[0];
    assign halted       = state == HALT;
    assign pop          = if_valid && if_ready;
    assign slot         = pop ? count == 2'd2 : count == 2'd1;
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        push     = 1'b0;
        flush    = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                state_nx = start ? RUN : IDLE;
                pc_nx    = (redirect_valid && redirect_pc[1:0] == 2'b00) ? redirect_pc : pc;
            end
            RUN: begin
                if (redirect_valid) begin
                    flush    = 1'b1;
                    err_set  = redirect_pc[1:0] != 2'b00;
                    state_nx = err_set ? HALT : RUN;
                    pc_nx    = err_set ? pc : redirect_pc;
                end else if (pc > LAST_ADDR) begin
                    state_nx = HALT;
                end else if (count != 2'd2 || pop) begin
                    push  = 1'b1;
                    pc_nx = pc + 64'd4;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            count        <= 2'd0;
            misalign_err <= 1'b0;
            pc_q[0]      <= 64'd0;
            pc_q[1]      <= 64'd0;
            instr_q[0]   <= 32'd0;
            instr_q[1]   <= 32'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (err_set)
                misalign_err <= 1'b1;
            if (flush) begin
                count <= 2'd0;
            end else begin
                count <= count - {1'b0, pop} + {1'b0, push};
                if (pop) begin
                    pc_q[0]    <= pc_q[1];
                    instr_q[0] <= instr_q[1];
                end
                // written after the shift so an entry landing at the head wins
                if (push) begin
                    pc_q[slot]    <= pc;
                    instr_q[slot] <= Instruction;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus randomized run against a queue-based fetch model
module tb_fetch_controller;
    localparam logic [63:0] LAST = 64'd144;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic [63:0] Inst_Address, if_pc;
    logic [31:0] Instruction, if_instr;
    logic        if_valid, halted, misalign_err;
    logic [31:0] mem [64];
    ent_t        m_q [$];
    logic [63:0] m_pc = 64'd0;
    int          m_mode = 0;
    logic        m_err = 1'b0;
    int          tests = 0, fails = 0;
    always #5 clk = ~clk;
    assign Instruction = mem[Inst_Address[7:2]];
    fetch_controller #(.RESET_PC(64'd0), .LAST_ADDR(LAST)) dut (
        .clk(clk), .reset(reset), .start(start), .Inst_Address(Inst_Address),
        .Instruction(Instruction), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .halted(halted), .misalign_err(misalign_err)
    );
    // One clock: the model consumes the same inputs the DUT samples, then outputs settle by negedge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_pc   = 64'd0;
            m_mode = 0;
            m_err  = 1'b0;
        end else if (m_mode == 0) begin
            if (redirect_valid && redirect_pc[1:0] == 2'b00) m_pc = redirect_pc;
            if (start) m_mode = 1;
        end else if (m_mode == 1 && redirect_valid) begin
            m_q.delete();
            if (redirect_pc[1:0] != 2'b00) begin
                m_err  = 1'b1;
                m_mode = 2;
            end else m_pc = redirect_pc;
        end else begin
            if (m_q.size() > 0 && if_ready) void'(m_q.pop_front());
            if (m_mode == 1) begin
                if (m_pc > LAST) m_mode = 2;
                else if (m_q.size() < 2) begin
                    m_q.push_back('{m_pc, mem[m_pc[7:2]]});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
        @(negedge clk);
    endtask
    task automatic do_reset();
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        do_reset();
        tests++;
        if ({if_valid, if_pc, if_instr, Inst_Address, halted, misalign_err} !== 164'd0) begin
            fails++;
            $display("FAIL reset: got v=%0b pc=%0d ins=%h ia=%0d h=%0b e=%0b, exp all zero", if_valid, if_pc, if_instr, Inst_Address, halted, misalign_err);
        end
    endtask
    task automatic test_stream();
        do_reset();
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (if_valid !== 1'b0) begin fails++; $display("FAIL t1_latency: got valid=%0b exp 0", if_valid); end
        tick();
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 64'd0) begin fails++; $display("FAIL t1_first: got v=%0b pc=%0d exp v=1 pc=0", if_valid, if_pc); end
        tests++;
        if (if_instr !== 32'h00600593) begin fails++; $display("FAIL t1_instr: got %h exp 00600593", if_instr); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (if_valid !== 1'b1 || if_pc !== 64'(4 * k)) begin fails++; $display("FAIL t1_stream: got v=%0b pc=%0d exp v=1 pc=%0d", if_valid, if_pc, 4 * k); end
        end
    endtask
    task automatic test_backpressure();
        do_reset();
        start = 1'b1; if_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) tick();
        tests++;
        if (Inst_Address !== 64'd8 || if_pc !== 64'd0 || if_valid !== 1'b1) begin
            fails++; $display("FAIL t2_stall: got ia=%0d pc=%0d v=%0b exp ia=8 pc=0 v=1", Inst_Address, if_pc, if_valid);
        end
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (if_valid !== 1'b1 || if_pc !== 64'(4 * k)) begin fails++; $display("FAIL t2_drain: got v=%0b pc=%0d exp v=1 pc=%0d", if_valid, if_pc, 4 * k); end
            tick();
        end
    endtask
    task automatic test_redirect();
        do_reset();
        start = 1'b1; if_ready = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 64'd44;
        tick();
        redirect_valid = 1'b0;
        tests++;
        if (if_valid !== 1'b0 || Inst_Address !== 64'd44) begin fails++; $display("FAIL t3_flush: got v=%0b ia=%0d exp v=0 ia=44", if_valid, Inst_Address); end
        tick();
        tests++;
        if (if_valid !== 1'b1 || if_pc !== 64'd44 || if_instr !== 32'h00000F13) begin
            fails++; $display("FAIL t3_target: got v=%0b pc=%0d ins=%h exp v=1 pc=44 ins=00000f13", if_valid, if_pc, if_instr);
        end
    endtask
    task automatic test_misalign();
        logic [63:0] pa;
        do_reset();
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        pa = Inst_Address;
        redirect_valid = 1'b1; redirect_pc = 64'd46;
        tick();
        redirect_valid = 1'b0;
        tests++;
        if ({misalign_err, halted, if_valid} !== 3'b110 || Inst_Address !== pa) begin
            fails++; $display("FAIL t4_err: got e=%0b h=%0b v=%0b ia=%0d exp e=1 h=1 v=0 ia=%0d", misalign_err, halted, if_valid, Inst_Address, pa);
        end
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'd8;
        tick(); tick(); tick();
        start = 1'b0; redirect_valid = 1'b0;
        tests++;
        if ({misalign_err, halted, if_valid} !== 3'b110 || Inst_Address !== pa) begin
            fails++; $display("FAIL t4_frozen: got e=%0b h=%0b v=%0b ia=%0d exp e=1 h=1 v=0 ia=%0d", misalign_err, halted, if_valid, Inst_Address, pa);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({misalign_err, halted} !== 2'b00 || Inst_Address !== 64'd0) begin
            fails++; $display("FAIL t4_clear: got e=%0b h=%0b ia=%0d exp e=0 h=0 ia=0", misalign_err, halted, Inst_Address);
        end
    endtask
    task automatic test_end();
        logic [63:0] last_pc = '1;
        int n = 0;
        do_reset();
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        while (!halted && n < 100) begin
            tick();
            n++;
            if (if_valid) last_pc = if_pc;
        end
        tick(); tick();
        tests++;
        if (last_pc !== LAST || halted !== 1'b1 || if_valid !== 1'b0 || Inst_Address !== LAST + 64'd4) begin
            fails++; $display("FAIL t5_end: got last=%0d h=%0b v=%0b ia=%0d exp last=144 h=1 v=0 ia=148", last_pc, halted, if_valid, Inst_Address);
        end
    endtask
    task automatic test_reset_mid();
        do_reset();
        start = 1'b1; if_ready = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (if_valid !== 1'b0 || Inst_Address !== 64'd0 || halted !== 1'b0) begin
            fails++; $display("FAIL t6_reset: got v=%0b ia=%0d h=%0b exp v=0 ia=0 h=0", if_valid, Inst_Address, halted);
        end
        tick(); tick();
        tests++;
        if (if_valid !== 1'b0 || Inst_Address !== 64'd0) begin
            fails++; $display("FAIL t6_idle: got v=%0b ia=%0d exp v=0 ia=0 (still idle)", if_valid, Inst_Address);
        end
    endtask
    task automatic test_random();
        ent_t head;
        logic ev;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 299) == 0);
            start          = ($urandom_range(0, 9) == 0);
            if_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 64'($urandom_range(0, 40) * 4) + (($urandom_range(0, 19) == 0) ? 64'($urandom_range(1, 3)) : 64'd0);
            tick();
            ev   = m_q.size() != 0;
            head = ev ? m_q[0] : '{64'd0, 32'd0};
            tests++;
            if (if_valid !== ev || (ev && {if_pc, if_instr} !== {head.pc, head.ins}) || Inst_Address !== m_pc
                || halted !== (m_mode == 2) || misalign_err !== m_err) begin
                fails++;
                $display("FAIL rand_c%0d: got v=%0b pc=%0d ins=%h ia=%0d h=%0b e=%0b exp v=%0b pc=%0d ins=%h ia=%0d h=%0b e=%0b",
                         c, if_valid, if_pc, if_instr, Inst_Address, halted, misalign_err,
                         ev, head.pc, head.ins, m_pc, m_mode == 2, m_err);
            end
        end
        reset = 1'b0; start = 1'b0; redirect_valid = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'h00600593;
        mem[11] = 32'h00000F13;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_end();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
